cam_pattern_tx: RTL and testbench
=================================

# cam_pattern_tx

Synthesizable OV7670-style parallel pixel-bus transmitter: generates pclk, vsync, href and an 8-bit byte stream carrying RGB444 pixels, exactly as the camera capture path consumes them. It stands in for the physical camera on the JB/JC pins during bring-up and simulation, driving known test patterns into the capture writer feeding `buffer_mem`. Frame geometry is parameterized so benches can use tiny frames.

## Interface
- `H_ACTIVE`, 640, active pixels per line; multiple of 8.
- `V_ACTIVE`, 480, active lines per frame.
- `H_BLANK`, 144, pclk periods with href low after each line's active bytes.
- `VSYNC_LINES`, 3, lines with vsync high.
- `V_BACK`, 17, lines after vsync before the first active line.
- `V_FRONT`, 10, lines after the last active line.
- `clk`  in  1  system clock; pclk runs at clk/2.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  level; frames are generated while high.
- `pattern`  in  2  0 colour bars, 1 gradient, 2 solid, 3 checkerboard.
- `solid_rgb`  in  12  {R,G,B} for pattern 2.
- `pclk`  out  1  pixel clock to the receiver.
- `vsync`  out  1  high during the VSYNC phase.
- `href`  out  1  high while active bytes are driven.
- `data`  out  8  pixel byte.
- `frame_done`  out  1  one-clk pulse at the end of every frame.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- pclk toggles on every clk edge after reset, free-running in all states.
- Bus outputs (`vsync`, `href`, `data`) and all counters update only on the clk edge where pclk goes 1→0 (the "fall edge"). They are therefore stable across each pclk rising edge.
- Line length L = 2·H_ACTIVE + H_BLANK pclk periods, counted by `h_cnt` from 0 to L−1 and then wrapping. `line_cnt` counts lines within the current state.
- States:
  - IDLE: all bus outputs are 0. On a fall edge with `start`=1, latch `pattern` and `solid_rgb`, then go to VSYNC with h_cnt=0.
  - VSYNC: vsync=1 for VSYNC_LINES·L pclk periods, then go to VBACK.
  - VBACK: V_BACK lines with all bus outputs low, then go to ACTIVE.
  - ACTIVE: V_ACTIVE lines.
    - For h_cnt < 2·H_ACTIVE: href=1, pixel x = h_cnt>>1, byte0 = {R,G}, byte1 = {B,4'h0}.
    - Otherwise href=0 and data=0.
    - After the last line, go to VFRONT.
  - VFRONT: V_FRONT lines with all bus outputs low. At the end, pulse `frame_done`, increment the 4-bit `frame_cnt`, then:
    - `start`=1: go straight to VSYNC (relatch pattern and colour).
    - otherwise: go to IDLE.
- Zero-length phases (any of VSYNC_LINES, V_BACK, V_FRONT = 0) are skipped.
- Patterns (x = active pixel index, y = active line index):
  - Bars: 8 bars of H_ACTIVE/8 pixels each, in order FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Gradient: {x[3:0], y[3:0], frame_cnt}.
  - Solid: the latched `solid_rgb`.
  - Checker: FFF if x[3]^y[3], else 000.
- Deasserting `start` mid-frame has no effect until the frame completes.
- `pattern` and `solid_rgb` changes take effect only at the next frame start.

## Timing
- Reset (asynchronous) forces: pclk=0, vsync=0, href=0, data=0, frame_done=0, busy=0, state IDLE, all counters 0.
  - Reset mid-frame aborts the frame immediately, with no `frame_done`.
- The first pclk rise comes 1 clk after reset release; the first fall edge comes 2 clks after release.
- `start` is sampled only on fall edges.
  - vsync rises on the first fall edge with start=1.
  - Worst-case latency from `start` assertion to vsync high: 2 clk.
- `href` and the first byte of line 0 appear on the fall edge exactly (VSYNC_LINES+V_BACK)·L pclk periods after vsync rose.
- Each byte is held 2 clk.
  - byte0 is driven when h_cnt is even, byte1 when h_cnt is odd.
  - href is high for exactly 2·H_ACTIVE consecutive pclk periods per active line.
- Frame period is (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)·L pclk periods, i.e. twice that in clk.
- `frame_done` is high for 1 clk, coincident with the fall edge that ends VFRONT.
  - In back-to-back mode, the same fall edge raises vsync for the next frame.

## Test plan
All scenarios use H_ACTIVE=8, H_BLANK=4, V_ACTIVE=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, so L=20 and the frame is 100 pclk = 200 clk.

- **Reset state:** reset held 5 clk, start=0 → all outputs 0; pclk toggles every clk after release; vsync and href stay 0.
- **Bars framing:** start=1, pattern=0.
  - vsync high for exactly 20 pclk.
  - href high for 16 pclk on 2 lines, low for 4 pclk after each.
  - Line 0 bytes: FF,F0,FF,00,0F,F0,0F,00,F0,F0,F0,00,00,F0,00,00.
  - frame_done pulses once, 200 clk after vsync first rose.
- **Solid and relatch:** pattern=2, solid_rgb=12'hA5C → every pixel pair is A5,C0. Changing solid_rgb to 123 mid-frame changes nothing until the next frame, which carries 12,30.
- **Start dropped mid-frame:** start falls during ACTIVE → the frame completes, frame_done pulses, state returns to IDLE, busy=0, and vsync is not reasserted.
- **Reset mid-frame:** reset asserted during ACTIVE → vsync, href and data go to 0 in the same clk; no frame_done. After release with start=1, the next frame begins cleanly with vsync.
- **Loopback:** connect to the capture logic (writing RGB444 into `buffer_mem`) with the gradient pattern → captured word at pixel (x=3, y=1) of frame 0 is 12'h310.

Source files
------------

// File: rtl/cam_pattern_tx.sv
// OV7670-style parallel pixel-bus transmitter with built-in RGB444 test patterns.
// pclk runs at clk/2; every bus change happens on the clk edge where pclk falls,
// so vsync/href/data are stable across each pclk rising edge.
module cam_pattern_tx #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  pattern,
  input  logic [11:0] solid_rgb,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned LineLen  = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HW       = (LineLen > 1) ? $clog2(LineLen) : 1;
  localparam int unsigned MaxA     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned MaxB     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned MaxLines = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned LW       = $clog2(MaxLines + 1);
  localparam int unsigned BarW     = H_ACTIVE / 8;

  typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

  // Zero-length vertical phases are skipped by choosing the next non-empty phase.
  localparam state_e FrameFirst = (VSYNC_LINES != 0) ? StVsync :
                                  ((V_BACK != 0) ? StVback : StActive);
  localparam state_e AfterVsync = (V_BACK != 0) ? StVback : StActive;

  state_e        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [3:0]    frame_cnt_q, frame_cnt_d;
  logic [1:0]    pat_q, pat_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          pclk_q;
  logic          frame_done_q;

  logic          fall;
  logic          line_end;
  logic          phase_done;
  logic          frame_end;
  int unsigned   phase_lines;

  logic [15:0]   x;
  logic [3:0]    y;
  logic [2:0]    bar;
  logic [11:0]   pix;
  logic          active_byte;

  // pclk is high just before the edge that drops it, so pclk_q marks the fall edge.
  assign fall = pclk_q;

  // Length in lines of the phase currently being played out.
  always_comb begin
    phase_lines = 0;
    case (state_q)
      StVsync:  phase_lines = VSYNC_LINES;
      StVback:  phase_lines = V_BACK;
      StActive: phase_lines = V_ACTIVE;
      StVfront: phase_lines = V_FRONT;
      default:  phase_lines = 0;
    endcase
  end

  assign line_end   = (32'(h_cnt_q) + 1) == LineLen;
  assign phase_done = (32'(line_cnt_q) + 1) == phase_lines;

  // Next-state, counter and latch logic; only fall edges advance anything.
  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    line_cnt_d  = line_cnt_q;
    frame_cnt_d = frame_cnt_q;
    pat_d       = pat_q;
    rgb_d       = rgb_q;
    frame_end   = 1'b0;
    if (fall) begin
      if (state_q == StIdle) begin
        if (start) begin
          state_d    = FrameFirst;
          h_cnt_d    = '0;
          line_cnt_d = '0;
          pat_d      = pattern;
          rgb_d      = solid_rgb;
        end
      end else begin
        h_cnt_d = line_end ? '0 : h_cnt_q + 1'b1;
        if (line_end) begin
          line_cnt_d = phase_done ? '0 : line_cnt_q + 1'b1;
          if (phase_done) begin
            case (state_q)
              StVsync:  state_d = AfterVsync;
              StVback:  state_d = StActive;
              StActive: begin
                if (V_FRONT != 0) state_d = StVfront;
                else              frame_end = 1'b1;
              end
              StVfront: frame_end = 1'b1;
              default:  state_d = StIdle;
            endcase
          end
        end
        if (frame_end) begin
          frame_cnt_d = frame_cnt_q + 4'd1;
          if (start) begin
            state_d = FrameFirst;
            pat_d   = pattern;
            rgb_d   = solid_rgb;
          end else begin
            state_d = StIdle;
          end
        end
      end
    end
  end

  // State, counters, latched pattern settings, pclk and the frame_done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      h_cnt_q      <= '0;
      line_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      pat_q        <= '0;
      rgb_q        <= '0;
      pclk_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      line_cnt_q   <= line_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      pat_q        <= pat_d;
      rgb_q        <= rgb_d;
      pclk_q       <= ~pclk_q;
      frame_done_q <= frame_end;
    end
  end

  // Pixel colour for the current active position.
  always_comb begin
    x   = 16'(h_cnt_q >> 1);
    y   = 4'(line_cnt_q);
    bar = 3'(32'(x) / BarW);
    pix = 12'h000;
    case (pat_q)
      // Bar order FFF,FF0,0FF,0F0,F0F,F00,00F,000: each channel is a bit of the index.
      2'd0:    pix = {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}};
      2'd1:    pix = {x[3:0], y, frame_cnt_q};
      2'd2:    pix = rgb_q;
      default: pix = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
    endcase
  end

  // Bus outputs decoded from registered state, so they only move on fall edges.
  always_comb begin
    active_byte = (state_q == StActive) && (32'(h_cnt_q) < 2 * H_ACTIVE);
    vsync       = (state_q == StVsync);
    href        = active_byte;
    data        = 8'h00;
    if (active_byte) data = h_cnt_q[0] ? {pix[3:0], 4'h0} : pix[11:4];
  end

  assign pclk       = pclk_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Bench for cam_pattern_tx: frame-time model compared every clk, a capture process
// acting as the receiver, and directed literal checks on captured bytes and timing.
module tb_cam_pattern_tx;

  localparam int HA = 8;
  localparam int VA = 2;
  localparam int HB = 4;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int L  = 2 * HA + HB;
  localparam int FRAME = (VS + VB + VA + VF) * L;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic        pclk, vsync, href, frame_done, busy;
  logic [7:0]  data;

  int n_cmp = 0;
  int n_bad = 0;

  cam_pattern_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .solid_rgb(solid_rgb),
    .pclk(pclk), .vsync(vsync), .href(href), .data(data),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: time since frame start ----------------
  int          m_t = 0;
  int          m_frame = 0;
  bit          m_run = 0;
  bit          m_pclk = 0;
  bit          m_done = 0;
  logic [1:0]  m_pat = 2'd0;
  logic [11:0] m_rgb = 12'h000;

  function automatic logic [11:0] exp_pix(input int px, input int py, input logic [1:0] pat,
                                          input logic [11:0] rgb, input int fr);
    logic [11:0] r;
    r = 12'h000;
    case (pat)
      2'd0: begin
        case ((px * 8) / HA)
          0: r = 12'hFFF;
          1: r = 12'hFF0;
          2: r = 12'h0FF;
          3: r = 12'h0F0;
          4: r = 12'hF0F;
          5: r = 12'hF00;
          6: r = 12'h00F;
          default: r = 12'h000;
        endcase
      end
      2'd1: r = 12'((px % 16) * 256 + (py % 16) * 16 + (fr % 16));
      2'd2: r = rgb;
      default: r = (((px / 8) % 2) != ((py / 8) % 2)) ? 12'hFFF : 12'h000;
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t = 0; m_frame = 0; m_run = 0; m_pclk = 0; m_done = 0;
      m_pat = 2'd0; m_rgb = 12'h000;
    end else begin
      m_done = 0;
      if (m_pclk) begin
        if (m_run) begin
          m_t++;
          if (m_t == FRAME) begin
            m_done = 1;
            m_frame = (m_frame + 1) % 16;
            m_t = 0;
            if (start) begin m_pat = pattern; m_rgb = solid_rgb; end
            else m_run = 0;
          end
        end else if (start) begin
          m_run = 1; m_t = 0; m_pat = pattern; m_rgb = solid_rgb;
        end
      end
      m_pclk = !m_pclk;
    end
  end

  // Compare every output against the model, away from the active edge.
  int          c_ln, c_h;
  logic        c_v, c_hr;
  logic [7:0]  c_d;
  logic [11:0] c_p;
  always @(negedge clk) begin
    c_ln = m_t / L;
    c_h  = m_t % L;
    c_v  = m_run && (c_ln < VS);
    c_hr = m_run && (c_ln >= VS + VB) && (c_ln < VS + VB + VA) && (c_h < 2 * HA);
    c_d  = 8'h00;
    if (c_hr) begin
      c_p = exp_pix(c_h / 2, c_ln - VS - VB, m_pat, m_rgb, m_frame);
      c_d = (c_h % 2 == 0) ? c_p[11:4] : {c_p[3:0], 4'h0};
    end
    chk("m_pclk", pclk, m_pclk);
    chk("m_vsync", vsync, c_v);
    chk("m_href", href, c_hr);
    chk("m_data", data, c_d);
    chk("m_frame_done", frame_done, m_done);
    chk("m_busy", busy, m_run);
  end

  // ---------------- receiver: sample once per pclk period after it rises ----------------
  logic [7:0] cap_bytes [4][16];
  int         cap_len [4];
  int         cap_y = 0;
  int         cap_b = 0;
  always @(negedge clk) begin
    if (reset) begin
      cap_y = 0; cap_b = 0;
    end else if (pclk) begin
      if (vsync) begin
        cap_y = 0; cap_b = 0;
      end else if (href) begin
        if (cap_y < 4 && cap_b < 16) cap_bytes[cap_y][cap_b] = data;
        cap_b++;
      end else if (cap_b != 0) begin
        if (cap_y < 4) cap_len[cap_y] = cap_b;
        cap_y++;
        cap_b = 0;
      end
    end
  end

  task automatic wait_vsync(input int bound);
    int n;
    n = 0;
    while (vsync !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("vsync_rise_in_time", (n < bound), 1'b1);
  endtask

  // Counts negedge samples until frame_done is seen, and vsync-high samples before it.
  task automatic wait_done(input int bound, output int n_clk, output int n_vs);
    n_clk = 0;
    n_vs  = 0;
    while (frame_done !== 1'b1 && n_clk < bound) begin
      if (vsync === 1'b1) n_vs++;
      @(negedge clk);
      n_clk++;
    end
    chk("frame_done_in_time", (n_clk < bound), 1'b1);
  endtask

  logic [7:0]  bars_l0 [16] = '{8'hFF, 8'hF0, 8'hFF, 8'h00, 8'h0F, 8'hF0, 8'h0F, 8'h00,
                                 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h00};

  initial begin
    int nc, nv, cnt;
    logic [7:0]  b0, b1;
    logic [11:0] word;

    // Reset state.
    repeat (5) @(negedge clk);
    chk("rst_pclk", pclk, 1'b0);
    chk("rst_vsync", vsync, 1'b0);
    chk("rst_href", href, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("pclk_first_rise", pclk, 1'b1);
    @(negedge clk);
    chk("pclk_first_fall", pclk, 1'b0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (vsync || href || busy) cnt++;
    end
    chk("idle_quiet", cnt, 0);

    // Bars framing.
    start = 1'b1;
    pattern = 2'd0;
    wait_vsync(10);
    wait_done(400, nc, nv);
    chk("bars_frame_clk", nc, 200);
    chk("bars_vsync_pclk", nv / 2, 20);
    chk("bars_href_len0", cap_len[0], 16);
    chk("bars_href_len1", cap_len[1], 16);
    for (int i = 0; i < 16; i++) chk("bars_line0_byte", cap_bytes[0][i], bars_l0[i]);

    // Solid colour, then a mid-frame change that must wait for the next frame.
    pattern = 2'd2;
    solid_rgb = 12'hA5C;
    @(negedge clk);
    wait_done(400, nc, nv);
    chk("frame_period", nc, 199);
    repeat (100) @(negedge clk);
    solid_rgb = 12'h123;
    wait_done(400, nc, nv);
    for (int yy = 0; yy < 2; yy++)
      for (int i = 0; i < 16; i++)
        chk("solid_byte", cap_bytes[yy][i], (i % 2 == 0) ? 8'hA5 : 8'hC0);
    @(negedge clk);
    wait_done(400, nc, nv);
    chk("relatch_byte0", cap_bytes[0][0], 8'h12);
    chk("relatch_byte1", cap_bytes[0][1], 8'h30);
    chk("relatch_byte15", cap_bytes[1][15], 8'h30);

    // Start dropped mid-frame.
    @(negedge clk);
    repeat (100) @(negedge clk);
    start = 1'b0;
    wait_done(400, nc, nv);
    chk("drop_busy", busy, 1'b0);
    chk("drop_vsync", vsync, 1'b0);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (vsync || busy) cnt++;
    end
    chk("drop_stays_idle", cnt, 0);

    // Reset mid-frame, then a clean gradient frame.
    pattern = 2'd1;
    start = 1'b1;
    wait_vsync(10);
    repeat (100) @(negedge clk);
    chk("href_before_reset", href, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_vsync", vsync, 1'b0);
    chk("midrst_href", href, 1'b0);
    chk("midrst_data", data, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done) cnt++;
    end
    chk("midrst_no_done", cnt, 0);
    reset = 1'b0;
    wait_vsync(10);
    wait_done(400, nc, nv);
    chk("grad_frame_clk", nc, 200);
    b0 = cap_bytes[1][6];
    b1 = cap_bytes[1][7];
    word = {b0, b1[7:4]};
    chk("grad_x3_y1", word, 12'h310);
    b0 = cap_bytes[0][14];
    b1 = cap_bytes[0][15];
    word = {b0, b1[7:4]};
    chk("grad_x7_y0", word, 12'h700);

    start = 1'b0;
    @(negedge clk);
    wait_done(400, nc, nv);
    chk("end_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
